mcpi_mul_sched: RTL and testbench
=================================

MCPI_MUL_SCHED -- requirements
Module: mcpi_mul_sched

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports req0 and req1, input, 1 each, multiply request from requester 0 and requester 1.
REQ-004 SHALL have ports a0, b0, a1 and b1, input, 8 each, unsigned operands belonging to each requester.
REQ-005 SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle acceptance pulse; operands are captured on that edge.
REQ-006 SHALL have port busy, output, 1, high while an operation is in flight (states MUL and DONE).
REQ-007 SHALL have port done, output, 1, one-cycle pulse that marks result valid.
REQ-008 SHALL have port done_id, output, 1, identity of the requester that owns the current result.
REQ-009 SHALL have port result, output, 16, unsigned product a*b.
REQ-010 SHALL have ports mul_a and mul_b, output, 4 each, operands driven to the shared external 4x4 multiplier.
REQ-011 SHALL have port mul_p, input, 8, combinational product returned by the shared multiplier.

Function
REQ-012 SHALL use a state machine with states IDLE, MUL (step counter 0..3) and DONE.
REQ-013 SHALL, in IDLE with any req high, assert exactly one combinational gnt, capture that requester's a/b and id, and enter MUL step 0 on the next edge.
REQ-014 SHALL drive mul_a/mul_b per step: 0 = a[3:0]*b[3:0], 1 = a[7:4]*b[3:0], 2 = a[3:0]*b[7:4], 3 = a[7:4]*b[7:4]; outside MUL both SHALL be 0.
REQ-015 SHALL accumulate in a 16-bit register: step 0 loads mul_p; steps 1 and 2 add mul_p<<4; step 3 adds mul_p<<8; no overflow is possible.
REQ-016 SHALL load result and done_id at the end of step 3, then spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-017 SHALL give fixed latency: gnt in cycle T, done in cycle T+5; the next gnt is possible no earlier than T+6.
REQ-018 SHALL keep result and done_id stable from done until the next done.
REQ-019 SHALL ignore req inputs outside IDLE; a requester SHALL hold req until it sees its gnt.
REQ-020 SHALL never assert gnt0 and gnt1 in the same cycle, and SHALL never assert gnt while busy=1.

Reset
REQ-021 SHALL, on rst, go to IDLE and set gnt0=gnt1=0, busy=0, done=0, done_id=0, result=0x0000, mul_a=mul_b=0, accumulator=0 and last-grant=1.
REQ-022 SHALL treat rst asserted mid-operation as an abort: no done pulse for the aborted operation, and rst takes priority over every other event in the same cycle.

Configuration
REQ-023 SHALL, with macro MCPI_SCHED_RR_EN defined, arbitrate round-robin: when req0 and req1 are both high, grant the requester not granted last, and update last-grant on every gnt.
REQ-024 SHALL, without MCPI_SCHED_RR_EN, use fixed priority (req0 always wins); the last-grant register is then absent.

Verification
REQ-025 SHALL cover single request: req0, a0=0xFF, b0=0xFF -> gnt0 at T, done at T+5, result=0xFE01, done_id=0.
REQ-026 SHALL cover requester 1: req1, a1=0x12, b1=0x34 -> result=0x03A8, done_id=1; mul_a/mul_b sequence (2,4),(1,4),(2,3),(1,3).
REQ-027 SHALL cover round-robin (RR_EN defined): req0 and req1 both held, a0=0x80, b0=0x80, a1=0x03, b1=0x05 -> grants alternate 0,1,0, results 0x4000 and 0x000F, gnts 6 cycles apart.
REQ-028 SHALL cover fixed priority (RR_EN undefined): req0 and req1 both held for 20 cycles -> only gnt0 pulses (T, T+6, T+12, T+18) and gnt1 is never asserted.
REQ-029 SHALL cover reset mid-operation: rst asserted in MUL step 2 -> next cycle idle, busy=0, result=0x0000, no done pulse; a fresh req0 then completes normally.
REQ-030 SHALL cover request during busy: req1 raised at T+2 during the req0 operation -> no gnt1 until T+6, and gnt1 is asserted at T+6.

Source files
------------

// File: rtl/mcpi_mul_sched.sv
// Two-requester 8x8 multiply scheduler over a shared external 4x4 multiplier.
// Define MCPI_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module mcpi_mul_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] result,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        id_q, id_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] res_q, res_d;
  logic        did_q, did_d;
  logic        gnt_any;
  logic        pick1;

`ifdef MCPI_SCHED_RR_EN
  logic last_q, last_d;
  // last_q = 1 after reset so requester 0 wins the first tie
  assign pick1 = req1 & (~req0 | ~last_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  assign gnt_any = (state_q == IDLE) & (req0 | req1) & ~rst;
  assign gnt1    = gnt_any & pick1;
  assign gnt0    = gnt_any & ~pick1;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = did_q;
  assign result  = res_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    acc_d   = acc_q;
    res_d   = res_q;
    did_d   = did_q;
    mul_a   = 4'h0;
    mul_b   = 4'h0;
`ifdef MCPI_SCHED_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          id_d    = pick1;
          step_d  = 2'd0;
          acc_d   = 16'h0000;
          state_d = MUL;
`ifdef MCPI_SCHED_RR_EN
          last_d  = pick1;
`endif
        end
      end
      MUL: begin
        mul_a  = step_q[0] ? a_q[7:4] : a_q[3:0];
        mul_b  = step_q[1] ? b_q[7:4] : b_q[3:0];
        step_d = step_q + 2'd1;
        unique case (step_q)
          2'd0: acc_d = {8'h00, mul_p};
          2'd1,
          2'd2: acc_d = acc_q + {4'h0, mul_p, 4'h0};
          default: acc_d = acc_q + {mul_p, 8'h00};
        endcase
        if (step_q == 2'd3) begin
          res_d   = acc_d;
          did_d   = id_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      id_q    <= 1'b0;
      acc_q   <= 16'h0000;
      res_q   <= 16'h0000;
      did_q   <= 1'b0;
`ifdef MCPI_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      did_q   <= did_d;
`ifdef MCPI_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mcpi_mul_sched.sv
// Self-checking bench for mcpi_mul_sched with a result scoreboard.
// Covers round-robin or fixed priority depending on MCPI_SCHED_RR_EN.
module tb_mcpi_mul_sched;

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [15:0] result;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic        id;
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t em;

  assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

  mcpi_mul_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .done(done), .done_id(done_id),
    .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 | gnt1) begin
        chk("gnt_onehot", {31'h0, gnt0 & gnt1}, 0);
        chk("gnt_busy", {31'h0, busy}, 0);
        em.id  = gnt1;
        em.res = gnt1 ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
        em.cyc = cyc;
        sb.push_back(em);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          em = sb.pop_front();
          chk("sb_result", {16'h0, result}, {16'h0, em.res});
          chk("sb_done_id", {31'h0, done_id}, {31'h0, em.id});
          chk("sb_latency", cyc - em.cyc, 5);
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'h0, done}, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", n, n < 40 ? n : -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick();
    tick();
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_done_id", {31'h0, done_id}, 0);
    chk("rst_result", {16'h0, result}, 0);
    chk("rst_mul_ab", {24'h0, mul_a, mul_b}, 0);
    chk("rst_gnt", {30'h0, gnt0, gnt1}, 0);
    rst = 1'b0;
    tick();

    // single request 0xFF*0xFF
    req0 = 1; a0 = 8'hFF; b0 = 8'hFF;
    #1;
    chk("t25_gnt0", {31'h0, gnt0}, 1);
    tick();
    req0 = 0;
    chk("t25_busy", {31'h0, busy}, 1);
    wait_done();
    chk("t25_result", {16'h0, result}, 32'hFE01);
    chk("t25_id", {31'h0, done_id}, 0);
    tick();
    tick();
    tick();
    chk("t25_hold_res", {16'h0, result}, 32'hFE01);
    chk("t25_hold_id", {31'h0, done_id}, 0);

    // requester 1 with operand sequencing
    req1 = 1; a1 = 8'h12; b1 = 8'h34;
    #1;
    chk("t26_gnt1", {31'h0, gnt1}, 1);
    chk("t26_gnt0", {31'h0, gnt0}, 0);
    tick();
    req1 = 0;
    chk("t26_s0", {24'h0, mul_a, mul_b}, 32'h24);
    tick();
    chk("t26_s1", {24'h0, mul_a, mul_b}, 32'h14);
    tick();
    chk("t26_s2", {24'h0, mul_a, mul_b}, 32'h23);
    tick();
    chk("t26_s3", {24'h0, mul_a, mul_b}, 32'h13);
    tick();
    chk("t26_done", {31'h0, done}, 1);
    chk("t26_result", {16'h0, result}, 32'h03A8);
    chk("t26_id", {31'h0, done_id}, 1);
    chk("t26_mul_idle", {24'h0, mul_a, mul_b}, 0);
    tick();

    // request arriving while busy
    req0 = 1; a0 = 8'h0A; b0 = 8'h0B;
    #1;
    chk("t30_gnt0", {31'h0, gnt0}, 1);
    tick();
    req0 = 0;
    tick();
    req1 = 1; a1 = 8'h07; b1 = 8'h09;
    for (int i = 2; i < 6; i++) begin
      #1;
      chk($sformatf("t30_nognt1_%0d", i), {31'h0, gnt1}, 0);
      tick();
    end
    chk("t30_gnt1_T6", {31'h0, gnt1}, 1);
    tick();
    req1 = 0;
    drain();

    // reset during MUL step 2
    req0 = 1; a0 = 8'h55; b0 = 8'hAA;
    #1;
    chk("t29_gnt0", {31'h0, gnt0}, 1);
    tick();
    req0 = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    chk("t29_busy", {31'h0, busy}, 0);
    chk("t29_result", {16'h0, result}, 0);
    chk("t29_done", {31'h0, done}, 0);
    chk("t29_mul_ab", {24'h0, mul_a, mul_b}, 0);
    for (int i = 0; i < 6; i++) tick();
    req0 = 1; a0 = 8'h0F; b0 = 8'h11;
    #1;
    chk("t29_fresh_gnt0", {31'h0, gnt0}, 1);
    tick();
    req0 = 0;
    wait_done();
    chk("t29_fresh_res", {16'h0, result}, 32'h00FF);
    drain();

    do_reset();
`ifdef MCPI_SCHED_RR_EN
    req0 = 1; a0 = 8'h80; b0 = 8'h80;
    req1 = 1; a1 = 8'h03; b1 = 8'h05;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk($sformatf("t27_gnt0_%0d", i), {31'h0, gnt0}, (i == 0 || i == 12) ? 1 : 0);
      chk($sformatf("t27_gnt1_%0d", i), {31'h0, gnt1}, (i == 6) ? 1 : 0);
      if (i == 11) chk("t27_res1", {16'h0, result}, 32'h000F);
      if (i == 5) chk("t27_res0", {16'h0, result}, 32'h4000);
      tick();
    end
`else
    req0 = 1; a0 = 8'h80; b0 = 8'h80;
    req1 = 1; a1 = 8'h03; b1 = 8'h05;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("t28_gnt0_%0d", i), {31'h0, gnt0}, (i % 6 == 0) ? 1 : 0);
      chk($sformatf("t28_gnt1_%0d", i), {31'h0, gnt1}, 0);
      tick();
    end
`endif
    req0 = 0;
    req1 = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
